// File: rtl/dp_hpd_detector.sv
// rtl/dp_hpd_detector.sv - DP Hot Plug Detect qualifier (plug / unplug / IRQ / glitch)
//
// Ports:
//   clk         system clock, single domain
//   reset       synchronous active-high reset
//   HPD_Signal  raw HPD pin from the connector, asynchronous to clk
//   HPD_Detect  level, sink connected and qualified
//   HPD_IRQ     one-cycle pulse, valid sink IRQ seen while connected
module dp_hpd_detector #(
  parameter int CLK_FREQ_KHZ = 100000,
  parameter int T_PLUG       = 2 * CLK_FREQ_KHZ,
  parameter int T_IRQ_MIN    = CLK_FREQ_KHZ / 2,
  parameter int T_IRQ_MAX    = CLK_FREQ_KHZ,
  parameter int CNT_W        = $clog2(T_PLUG + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic HPD_Signal,
  output logic HPD_Detect,
  output logic HPD_IRQ
);

  typedef enum logic [1:0] {
    ST_DISCONNECTED = 2'd0,
    ST_PLUG_WAIT    = 2'd1,
    ST_CONNECTED    = 2'd2,
    ST_LOW_MEAS     = 2'd3
  } state_t;

  // Thresholds pre-cast to counter width so every compare is unsigned at CNT_W.
  localparam logic [CNT_W-1:0] L_PLUG_LAST = CNT_W'(T_PLUG - 1);
  localparam logic [CNT_W-1:0] L_IRQ_MIN   = CNT_W'(T_IRQ_MIN);
  localparam logic [CNT_W-1:0] L_IRQ_MAX   = CNT_W'(T_IRQ_MAX);
  localparam logic [CNT_W-1:0] L_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_CNT_MAX   = {CNT_W{1'b1}};

  logic             r_sync_meta;
  logic             r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_detect;
  logic             r_irq;

  logic             w_hpd_s;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_detect_nxt;
  logic             w_irq_nxt;

  // Two-flop synchroniser; the FSM only ever looks at the second stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= HPD_Signal;
      r_sync      <= r_sync_meta;
    end
  end

  assign w_hpd_s = r_sync;

  // Run-length counter never wraps, even if thresholds are misconfigured.
  assign w_cnt_inc = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + L_CNT_ONE;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_detect_nxt = r_detect;
    w_irq_nxt    = 1'b0;

    unique case (r_state)
      ST_DISCONNECTED: begin
        w_detect_nxt = 1'b0;
        if (w_hpd_s) begin
          // This sample is the first of the qualifying high run.
          w_state_nxt = ST_PLUG_WAIT;
          w_cnt_nxt   = L_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      ST_PLUG_WAIT: begin
        w_detect_nxt = 1'b0;
        if (!w_hpd_s) begin
          // Any low sample restarts qualification from scratch.
          w_state_nxt = ST_DISCONNECTED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= L_PLUG_LAST) begin
          // This edge takes the T_PLUG-th consecutive high sample.
          w_state_nxt  = ST_CONNECTED;
          w_cnt_nxt    = '0;
          w_detect_nxt = 1'b1;
        end else begin
          w_cnt_nxt    = w_cnt_inc;
        end
      end

      ST_CONNECTED: begin
        w_detect_nxt = 1'b1;
        if (!w_hpd_s) begin
          w_state_nxt = ST_LOW_MEAS;
          w_cnt_nxt   = L_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      ST_LOW_MEAS: begin
        // Detect holds while the low run is still ambiguous between IRQ and unplug.
        if (!w_hpd_s) begin
          if (r_cnt >= L_IRQ_MAX) begin
            // Low run now exceeds the longest IRQ: the sink is gone.
            w_state_nxt  = ST_DISCONNECTED;
            w_cnt_nxt    = '0;
            w_detect_nxt = 1'b0;
          end else begin
            w_cnt_nxt    = w_cnt_inc;
          end
        end else begin
          // Run ended with r_cnt low samples; r_cnt <= T_IRQ_MAX holds here.
          w_state_nxt = ST_CONNECTED;
          w_cnt_nxt   = '0;
          w_irq_nxt   = (r_cnt >= L_IRQ_MIN);
        end
      end

      default: begin
        w_state_nxt  = ST_DISCONNECTED;
        w_cnt_nxt    = '0;
        w_detect_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_DISCONNECTED;
      r_cnt    <= '0;
      r_detect <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_detect <= w_detect_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  assign HPD_Detect = r_detect;
  assign HPD_IRQ    = r_irq;

endmodule
